// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operating-mode
// encoding and the width of the mode select.
package usr_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ASR  = 3'd5,
        MODE_LOAD = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

endpackage

// File: rtl/usr_if.sv
// Control and data bundle of the universal shift register.
// There is no valid/ready handshake: every control input is sampled on each
// rising clock edge, and every output is valid from one edge to the next.
// The master drives the controls and observes the register state.
// The slave is the register itself.
interface usr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) ();
    logic               sync_clear;
    logic               shift_enable;
    usr_pkg::mode_e     mode;
    logic               serial_in;
    logic [WIDTH-1:0]   load_data;
    logic [WIDTH-1:0]   stored_data;
    logic               serial_out_msb;
    logic               serial_out_lsb;
    logic [CNT_W-1:0]   shift_count;
    logic               frame_done;

    modport master (
        output sync_clear, shift_enable, mode, serial_in, load_data,
        input  stored_data, serial_out_msb, serial_out_lsb, shift_count, frame_done
    );

    modport slave (
        input  sync_clear, shift_enable, mode, serial_in, load_data,
        output stored_data, serial_out_msb, serial_out_lsb, shift_count, frame_done
    );
endinterface

// File: rtl/usr_frame_counter.sv
// Modulo-WIDTH shift counter. Emits a one-cycle frame_done pulse on the
// cycle after the WIDTH-th shift. The count restarts on clear and on load.
module usr_frame_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_restart,
    output logic [CNT_W-1:0] o_count,
    output logic             o_frame_done
);
    logic [CNT_W-1:0] r_count;
    logic             r_frame_done;
    logic             w_wrap;

    assign w_wrap = (r_count == CNT_W'(WIDTH - 1));

    // Count shifts. The pulse is only raised by the wrapping shift and is
    // cleared on every other kind of cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else if (i_clear) begin
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else if (i_shift) begin
            r_count      <= w_wrap ? '0 : r_count + CNT_W'(1);
            r_frame_done <= w_wrap;
        end else if (i_restart) begin
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign o_count      = r_count;
    assign o_frame_done = r_frame_done;
endmodule

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold, shift left/right, rotate
// left/right, arithmetic right shift and parallel load. It also provides
// serial outputs, a shift counter and a frame-complete pulse.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    usr_if.slave bus
);
    logic [WIDTH-1:0] r_data;
    logic             w_shift;
    logic             w_load;
    logic [CNT_W-1:0] w_count;
    logic             w_frame_done;

    // Modes 1..5 are counted shifts. LOAD restarts the frame.
    assign w_shift = bus.shift_enable && (bus.mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
    assign w_load  = bus.shift_enable && (bus.mode == MODE_LOAD);

    // Datapath. Clear wins over enable, and enable wins over mode.
    // HOLD and the reserved code leave the contents untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= RESET_VALUE;
        end else if (bus.sync_clear) begin
            r_data <= RESET_VALUE;
        end else if (bus.shift_enable) begin
            case (bus.mode)
                MODE_SHL:  r_data <= {r_data[WIDTH-2:0], bus.serial_in};
                MODE_SHR:  r_data <= {bus.serial_in, r_data[WIDTH-1:1]};
                MODE_ROL:  r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                MODE_ROR:  r_data <= {r_data[0], r_data[WIDTH-1:1]};
                MODE_ASR:  r_data <= {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                MODE_LOAD: r_data <= bus.load_data;
                default:   r_data <= r_data;
            endcase
        end
    end

    usr_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk          (clk),
        .rst_n        (reset),
        .i_clear      (bus.sync_clear),
        .i_shift      (w_shift),
        .i_restart    (w_load),
        .o_count      (w_count),
        .o_frame_done (w_frame_done)
    );

    assign bus.stored_data    = r_data;
    assign bus.serial_out_msb = r_data[WIDTH-1];
    assign bus.serial_out_lsb = r_data[0];
    assign bus.shift_count    = w_count;
    assign bus.frame_done     = w_frame_done;
endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the 8-bit serial-in shift register: configurable width and reset value.
- Selectable operating modes: hold, shift left/right, rotate left/right, arithmetic right shift, parallel load.
- Provides serial outputs, a shift counter and a frame-complete pulse after WIDTH shifts.
- Used wherever the design serialises or deserialises words (SPI-style links, bit-stream capture).

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into stored_data on reset and on sync_clear.
- CNT_W, $clog2(WIDTH), width of shift_count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- sync_clear  input  1  synchronous clear; highest priority below reset.
- shift_enable  input  1  qualifies every mode except HOLD; 0 = hold.
- mode  input  3  operation select (encodings below).
- serial_in  input  1  bit inserted by SHL/SHR.
- load_data  input  WIDTH  parallel load value.
- stored_data  output  WIDTH  register contents.
- serial_out_msb  output  1  equals stored_data[WIDTH-1].
- serial_out_lsb  output  1  equals stored_data[0].
- shift_count  output  CNT_W  shifts performed since last load/clear/wrap.
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset (reset=0, asynchronous):
  - stored_data=RESET_VALUE, shift_count=0, frame_done=0.
  - Reset is held while asserted; release is sampled on clk.
- Priority per rising edge: sync_clear > shift_enable=0 > mode.
- sync_clear=1: stored_data=RESET_VALUE, shift_count=0, frame_done=0, regardless of mode or enable.
- shift_enable=0: all state holds; frame_done=0.
- Mode encodings, applied when shift_enable=1:
  - 0 HOLD: no change.
  - 1 SHL: stored_data <= {stored_data[WIDTH-2:0], serial_in}.
  - 2 SHR: stored_data <= {serial_in, stored_data[WIDTH-1:1]}.
  - 3 ROL: stored_data <= {stored_data[WIDTH-2:0], stored_data[WIDTH-1]}.
  - 4 ROR: stored_data <= {stored_data[0], stored_data[WIDTH-1:1]}.
  - 5 ASR: stored_data <= {stored_data[WIDTH-1], stored_data[WIDTH-1:1]}.
  - 6 LOAD: stored_data <= load_data; shift_count=0.
  - 7 reserved: behaves as HOLD.
- Shift operations are modes 1-5 with shift_enable=1:
  - if shift_count==WIDTH-1, shift_count wraps to 0 and frame_done=1 on the next cycle;
  - otherwise shift_count increments and frame_done=0.
- frame_done:
  - registered; high for exactly one cycle.
  - Forced 0 by LOAD, HOLD, reserved, disabled and clear cycles.
- Latency: stored_data and the serial outputs update one clock after the qualifying edge; serial outputs are combinational from stored_data.
- Back-to-back frames: continuous shifting produces frame_done every WIDTH cycles with no gap cycle.
- Mid-frame changes:
  - A mode change between shift modes mid-frame does not reset shift_count.
  - LOAD mid-frame discards the partial count.
- Reset mid-operation: immediate return to reset values; there is no partial-frame recovery.

Decomposition:
- Shared package usr_pkg holds the mode enumeration (MODE_HOLD..MODE_LOAD, MODE_RSVD) and the 3-bit mode width constant.
- Optional sub-module usr_frame_counter: modulo-WIDTH shift counter with frame_done pulse generation; the datapath remains in the top module.

Test Plan:
- Reset and hold: reset=0 for 2 cycles, then release with WIDTH=8 and shift_enable=0 -> stored_data=00000000, shift_count=0, frame_done=0; state holds for 5 cycles.
- Serial fill (SHL):
  - Stimulus: serial_in sequence 1,0,1,1,0,0,1,0 over 8 enabled cycles.
  - Required: stored_data=10110010, shift_count back to 0, frame_done high for exactly 1 cycle, then 0.
- Load and rotate/ASR:
  - Stimulus: LOAD 8'h81, then ROL.
  - Required: ROL gives 00000011. ROR from 8'h81 gives 11000000. ASR from 8'h80 gives 11000000, then 11100000.
- Priority and clear:
  - sync_clear=1 together with LOAD 8'hFF -> stored_data=RESET_VALUE.
  - shift_enable=0 with mode=SHL for 3 cycles -> no change, shift_count unchanged.
- Mid-frame events:
  - Stimulus: 5 SHR shifts, then LOAD 8'h3C.
  - Required: shift_count=0 and frame_done stays 0. The next 8 shifts produce frame_done exactly once.
  - Asynchronous reset asserted mid-clock-period -> outputs go to reset values immediately.
- Parametrisation: repeat the serial-fill test at WIDTH=2 and WIDTH=16 with RESET_VALUE=16'hA5A5 -> frame_done period equals WIDTH, and the reset value is honoured.
